// File: rtl/triangle_2d_raster.sv
// Bounding-box triangle rasterizer: walks the screen-clipped bbox in raster order and streams
// every covered pixel over valid/ready; edge-function coverage matches triangle_2d_fill.
package triangle_2d_pkg;
  // [vertex][0=x,1=y][coordinate]
  typedef logic [2:0][1:0][11:0] tri_2d;
endpackage

module triangle_2d_raster
  import triangle_2d_pkg::*;
#(
  parameter int unsigned H_MAX = 1279,
  parameter int unsigned V_MAX = 719
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tri_valid_in,
  output logic        tri_ready_out,
  input  tri_2d       triangle,
  output logic        px_valid_out,
  input  logic        px_ready_in,
  output logic [11:0] px_hcount_out,
  output logic [11:0] px_vcount_out,
  output logic        tri_done_out,
  output logic        busy_out
);
  localparam logic [11:0] LP_HMAX = 12'(H_MAX);
  localparam logic [11:0] LP_VMAX = 12'(V_MAX);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SCAN, S_DRAIN, S_DONE} state_t;

  state_t r_state, w_next;
  logic        r_ready;
  logic [11:0] r_vx [3];
  logic [11:0] r_vy [3];
  logic [11:0] r_xmin, r_xmax, r_ymax, r_cx, r_cy;
  logic        r_s1_valid;
  logic [11:0] r_s1_h, r_s1_v;
  logic signed [25:0] r_pa [3];
  logic signed [25:0] r_pb [3];
  logic        r_px_valid;
  logic [11:0] r_px_h, r_px_v;

  logic [11:0] w_xmin, w_xmax, w_ymin, w_ymax, w_xmax_c, w_ymax_c;
  logic        w_empty, w_stall, w_issue, w_last, w_accept;
  logic signed [12:0] w_dpx [3];
  logic signed [12:0] w_dpy [3];
  logic signed [12:0] w_dax [3];
  logic signed [12:0] w_day [3];
  logic signed [25:0] w_pa [3];
  logic signed [25:0] w_pb [3];
  logic signed [26:0] w_d [3];
  logic        w_any_neg, w_any_pos, w_cov;

  assign w_accept = tri_valid_in & r_ready;
  // Only a held, unaccepted output pixel stalls; px_valid_out stays purely registered.
  assign w_stall  = r_px_valid & ~px_ready_in;
  assign w_issue  = (r_state == S_SCAN) & ~w_stall;
  assign w_last   = (r_cx == r_xmax) && (r_cy == r_ymax);

  always_comb begin
    w_xmin = r_vx[0];
    w_xmax = r_vx[0];
    w_ymin = r_vy[0];
    w_ymax = r_vy[0];
    for (int unsigned i = 1; i < 3; i++) begin
      if (r_vx[i] < w_xmin) w_xmin = r_vx[i];
      if (r_vx[i] > w_xmax) w_xmax = r_vx[i];
      if (r_vy[i] < w_ymin) w_ymin = r_vy[i];
      if (r_vy[i] > w_ymax) w_ymax = r_vy[i];
    end
    w_xmax_c = (w_xmax > LP_HMAX) ? LP_HMAX : w_xmax;
    w_ymax_c = (w_ymax > LP_VMAX) ? LP_VMAX : w_ymax;
    w_empty  = (w_xmin > LP_HMAX) || (w_ymin > LP_VMAX);
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = S_SETUP;
      S_SETUP: w_next = w_empty ? S_DONE : S_SCAN;
      S_SCAN:  if (w_issue && w_last) w_next = S_DRAIN;
      S_DRAIN: if (!r_s1_valid && !r_px_valid) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == S_IDLE);
    end
  end

  // Edge terms for the candidate: d = (px-bx)*(ay-by) - (ax-bx)*(py-by), b = next vertex.
  always_comb begin
    for (int unsigned e = 0; e < 3; e++) begin
      w_dpx[e] = $signed({1'b0, r_cx})          - $signed({1'b0, r_vx[(e + 1) % 3]});
      w_dpy[e] = $signed({1'b0, r_cy})          - $signed({1'b0, r_vy[(e + 1) % 3]});
      w_dax[e] = $signed({1'b0, r_vx[e]})       - $signed({1'b0, r_vx[(e + 1) % 3]});
      w_day[e] = $signed({1'b0, r_vy[e]})       - $signed({1'b0, r_vy[(e + 1) % 3]});
      w_pa[e]  = 26'(w_dpx[e]) * 26'(w_day[e]);
      w_pb[e]  = 26'(w_dax[e]) * 26'(w_dpy[e]);
    end
  end

  always_comb begin
    w_any_neg = 1'b0;
    w_any_pos = 1'b0;
    for (int unsigned e = 0; e < 3; e++) begin
      w_d[e]    = 27'(r_pa[e]) - 27'(r_pb[e]);
      w_any_neg = w_any_neg | w_d[e][26];
      w_any_pos = w_any_pos | (~w_d[e][26] & (w_d[e] != '0));
    end
    w_cov = ~(w_any_neg & w_any_pos);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 3; i++) begin
        r_vx[i] <= '0;
        r_vy[i] <= '0;
        r_pa[i] <= '0;
        r_pb[i] <= '0;
      end
      r_xmin     <= '0;
      r_xmax     <= '0;
      r_ymax     <= '0;
      r_cx       <= '0;
      r_cy       <= '0;
      r_s1_valid <= 1'b0;
      r_s1_h     <= '0;
      r_s1_v     <= '0;
      r_px_valid <= 1'b0;
      r_px_h     <= '0;
      r_px_v     <= '0;
    end else begin
      if (r_state == S_IDLE && w_accept) begin
        for (int unsigned i = 0; i < 3; i++) begin
          r_vx[i] <= triangle[i][0];
          r_vy[i] <= triangle[i][1];
        end
      end
      if (r_state == S_SETUP) begin
        r_xmin <= w_xmin;
        r_xmax <= w_xmax_c;
        r_ymax <= w_ymax_c;
        r_cx   <= w_xmin;
        r_cy   <= w_ymin;
      end else if (w_issue) begin
        if (r_cx == r_xmax) begin
          r_cx <= r_xmin;
          r_cy <= r_cy + 12'd1;
        end else begin
          r_cx <= r_cx + 12'd1;
        end
      end
      if (!w_stall) begin
        r_s1_valid <= w_issue;
        r_s1_h     <= r_cx;
        r_s1_v     <= r_cy;
        for (int unsigned i = 0; i < 3; i++) begin
          r_pa[i] <= w_pa[i];
          r_pb[i] <= w_pb[i];
        end
        r_px_valid <= r_s1_valid & w_cov;
        r_px_h     <= r_s1_h;
        r_px_v     <= r_s1_v;
      end
    end
  end

  assign tri_ready_out = r_ready;
  assign px_valid_out  = r_px_valid;
  assign px_hcount_out = r_px_h;
  assign px_vcount_out = r_px_v;
  assign tri_done_out  = (r_state == S_DONE);
  assign busy_out      = (r_state != S_IDLE);
endmodule

// File: tb/tb_triangle_2d_raster.sv
// Directed bench for triangle_2d_raster: hand-computed pixel sets plus an edge-function
// reference model for full-sequence comparison.
module tb_triangle_2d_raster;
  import triangle_2d_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tri_valid_in = 1'b0;
  logic        tri_ready_out;
  tri_2d       triangle = '0;
  logic        px_valid_out;
  logic        px_ready_in = 1'b0;
  logic [11:0] px_hcount_out;
  logic [11:0] px_vcount_out;
  logic        tri_done_out;
  logic        busy_out;

  triangle_2d_raster #(.H_MAX(1279), .V_MAX(719)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tri_valid_in  (tri_valid_in),
    .tri_ready_out (tri_ready_out),
    .triangle      (triangle),
    .px_valid_out  (px_valid_out),
    .px_ready_in   (px_ready_in),
    .px_hcount_out (px_hcount_out),
    .px_vcount_out (px_vcount_out),
    .tri_done_out  (tri_done_out),
    .busy_out      (busy_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [23:0] exp_q[$];
  logic [23:0] got_q[$];
  logic [23:0] ref_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit covered(input int px, input int py, input int vx[3], input int vy[3]);
    longint d;
    bit neg = 0;
    bit pos = 0;
    for (int e = 0; e < 3; e++) begin
      int b = (e + 1) % 3;
      d = longint'(px - vx[b]) * (vy[e] - vy[b]) - longint'(vx[e] - vx[b]) * (py - vy[b]);
      if (d < 0) neg = 1;
      if (d > 0) pos = 1;
    end
    return !(neg && pos);
  endfunction

  task automatic build_exp(input int vx[3], input int vy[3]);
    int xmin, xmax, ymin, ymax;
    exp_q.delete();
    xmin = vx[0]; xmax = vx[0]; ymin = vy[0]; ymax = vy[0];
    for (int i = 1; i < 3; i++) begin
      if (vx[i] < xmin) xmin = vx[i];
      if (vx[i] > xmax) xmax = vx[i];
      if (vy[i] < ymin) ymin = vy[i];
      if (vy[i] > ymax) ymax = vy[i];
    end
    if (xmax > 1279) xmax = 1279;
    if (ymax > 719) ymax = 719;
    if (xmin > 1279 || ymin > 719) return;
    for (int y = ymin; y <= ymax; y++)
      for (int x = xmin; x <= xmax; x++)
        if (covered(x, y, vx, vy)) exp_q.push_back({12'(x), 12'(y)});
  endtask

  task automatic wait_ready(input string tag);
    int w = 0;
    while (!tri_ready_out && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    check_eq({tag, ".ready"}, 32'(tri_ready_out), 1);
  endtask

  // Cycle k after the accept edge corresponds to T+k.
  task automatic run_tri(input int x0, input int y0, input int x1, input int y1,
                         input int x2, input int y2, input bit rnd, input string tag,
                         output int first_cyc, output int done_cyc);
    int vx[3], vy[3];
    int cyc, last_xfer, viol, nbad;
    bit prev_stall;
    logic [11:0] prev_h, prev_v;
    vx = '{x0, x1, x2};
    vy = '{y0, y1, y2};
    build_exp(vx, vy);
    got_q.delete();
    wait_ready(tag);
    for (int i = 0; i < 3; i++) begin
      triangle[i][0] = 12'(vx[i]);
      triangle[i][1] = 12'(vy[i]);
    end
    tri_valid_in = 1'b1;
    px_ready_in  = 1'b1;
    @(posedge clk); #1;
    tri_valid_in = 1'b0;
    triangle     = '1;
    cyc = 1; first_cyc = -1; done_cyc = -1; last_xfer = -1; viol = 0;
    prev_stall = 0; prev_h = '0; prev_v = '0;
    while (cyc < 8000) begin
      if (done_cyc >= 0) begin
        check_eq({tag, ".ready_after_done"}, 32'(tri_ready_out), 1);
        check_eq({tag, ".done_single"}, 32'(tri_done_out), 0);
        break;
      end
      if (prev_stall && (!px_valid_out || px_hcount_out != prev_h || px_vcount_out != prev_v))
        viol++;
      if (px_valid_out && first_cyc < 0) first_cyc = cyc;
      if (tri_done_out) done_cyc = cyc;
      px_ready_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (px_valid_out && px_ready_in) begin
        got_q.push_back({px_hcount_out, px_vcount_out});
        last_xfer = cyc;
      end
      prev_stall = px_valid_out && !px_ready_in;
      prev_h = px_hcount_out;
      prev_v = px_vcount_out;
      @(posedge clk); #1;
      cyc++;
    end
    px_ready_in = 1'b1;
    check_eq({tag, ".done_seen"}, 32'(done_cyc >= 0), 1);
    check_eq({tag, ".done_after_last"}, 32'(done_cyc > last_xfer), 1);
    check_eq({tag, ".count"}, 32'(got_q.size()), 32'(exp_q.size()));
    nbad = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) nbad++;
    check_eq({tag, ".seq_mismatches"}, 32'(nbad), 0);
    check_eq({tag, ".stall_unstable"}, 32'(viol), 0);
  endtask

  initial begin
    int f, d, nbad, maxh, maxv, n, guard;
    bit done_seen;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst.ready", 32'(tri_ready_out), 0);
    check_eq("rst.busy", 32'(busy_out), 0);
    check_eq("rst.done", 32'(tri_done_out), 0);
    check_eq("rst.px_valid", 32'(px_valid_out), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rst.ready_after_release", 32'(tri_ready_out), 1);

    // 1: right triangle, legs 10 -> rows of 11..1 pixels = 66
    run_tri(10, 10, 20, 10, 10, 20, 0, "t1", f, d);
    check_eq("t1.n66", 32'(got_q.size()), 66);
    if (got_q.size() > 0) begin
      check_eq("t1.first", 32'(got_q[0]), 32'({12'd10, 12'd10}));
      check_eq("t1.last", 32'(got_q[got_q.size() - 1]), 32'({12'd10, 12'd20}));
    end
    check_eq("t1.first_valid_T+4", 32'(f), 4);
    ref_q = got_q;

    // 2: opposite winding, identical stream
    run_tri(10, 10, 10, 20, 20, 10, 0, "t2", f, d);
    check_eq("t2.n", 32'(got_q.size()), 66);
    nbad = 0;
    for (int i = 0; i < got_q.size() && i < ref_q.size(); i++)
      if (got_q[i] !== ref_q[i]) nbad++;
    check_eq("t2.same_as_t1", 32'(nbad), 0);

    // 3: random backpressure, identical stream
    run_tri(10, 10, 20, 10, 10, 20, 1, "t3", f, d);
    check_eq("t3.n", 32'(got_q.size()), 66);
    nbad = 0;
    for (int i = 0; i < got_q.size() && i < ref_q.size(); i++)
      if (got_q[i] !== ref_q[i]) nbad++;
    check_eq("t3.same_as_t1", 32'(nbad), 0);

    // 4: degenerate triangles
    run_tri(0, 0, 5, 5, 10, 10, 0, "t4a", f, d);
    check_eq("t4a.n", 32'(got_q.size()), 11);
    nbad = 0;
    for (int i = 0; i < got_q.size(); i++)
      if (got_q[i] !== {12'(i), 12'(i)}) nbad++;
    check_eq("t4a.diag", 32'(nbad), 0);
    run_tri(7, 7, 7, 7, 7, 7, 0, "t4b", f, d);
    check_eq("t4b.n", 32'(got_q.size()), 1);
    if (got_q.size() > 0) check_eq("t4b.px", 32'(got_q[0]), 32'({12'd7, 12'd7}));

    // 5: clipped box 1270..1279 x 700..719, fully inside the triangle -> 200 pixels
    run_tri(1270, 700, 1300, 700, 1270, 730, 0, "t5a", f, d);
    check_eq("t5a.n", 32'(got_q.size()), 200);
    maxh = 0; maxv = 0;
    foreach (got_q[i]) begin
      if (int'(got_q[i][23:12]) > maxh) maxh = int'(got_q[i][23:12]);
      if (int'(got_q[i][11:0]) > maxv) maxv = int'(got_q[i][11:0]);
    end
    check_eq("t5a.max_h", 32'(maxh), 1279);
    check_eq("t5a.max_v", 32'(maxv), 719);
    run_tri(1300, 5, 1310, 5, 1305, 20, 0, "t5b", f, d);
    check_eq("t5b.n", 32'(got_q.size()), 0);
    check_eq("t5b.done_T+2", 32'(d), 2);

    // 6: async reset mid-scan after the 5th transfer
    wait_ready("t6");
    triangle[0][0] = 12'd10; triangle[0][1] = 12'd10;
    triangle[1][0] = 12'd20; triangle[1][1] = 12'd10;
    triangle[2][0] = 12'd10; triangle[2][1] = 12'd20;
    tri_valid_in = 1'b1;
    px_ready_in  = 1'b1;
    @(posedge clk); #1;
    tri_valid_in = 1'b0;
    n = 0; guard = 0;
    while (n < 5 && guard < 100) begin
      if (px_valid_out) n++;
      @(posedge clk); #1;
      guard++;
    end
    check_eq("t6.five_xfers", 32'(n), 5);
    rst_n = 1'b0;
    #1;
    check_eq("t6.px_valid_in_rst", 32'(px_valid_out), 0);
    check_eq("t6.busy_in_rst", 32'(busy_out), 0);
    done_seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (tri_done_out) done_seen = 1;
    end
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (tri_done_out) done_seen = 1;
    end
    check_eq("t6.no_done", 32'(done_seen), 0);
    check_eq("t6.ready_after_release", 32'(tri_ready_out), 1);
    for (int k = 0; k < 4; k++)
      run_tri($urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 40),
              $urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 40),
              1, $sformatf("t6r%0d", k), f, d);
    run_tri(1250, 690, 1279, 719, 1262, 705, 1, "t6edge", f, d);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
